// File: rtl/axis_byte_unpacker.sv
// axis_byte_unpacker
// Splits each AXI-Stream input word into single-byte AXI-Stream transfers.
// Bytes 0..n-1 of a word are emitted in order, where n is one past the
// highest set TKEEP bit. It also reports the byte length of each completed
// packet and keeps sticky flags for malformed TKEEP usage.
//
// Ports
//   ap_clk, ap_rst       clock, asynchronous active-high reset
//   inStream_*           input word stream (TDATA/TKEEP/TVALID/TREADY/TLAST)
//   outByte_*            output byte stream (TDATA/TVALID/TREADY/TLAST)
//   pkt_len              byte count of the last completed packet
//   pkt_done             one-cycle pulse whenever pkt_len is updated
//   err_keep             sticky: a TKEEP with a hole below its top set bit was seen
//   err_empty_last       sticky: a TLAST word with all-zero TKEEP was seen
module axis_byte_unpacker #(
    parameter int unsigned AXIS_TDATA_WIDTH = 64
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    input  logic [AXIS_TDATA_WIDTH-1:0]     inStream_TDATA,
    input  logic [AXIS_TDATA_WIDTH/8-1:0]   inStream_TKEEP,
    input  logic                            inStream_TVALID,
    output logic                            inStream_TREADY,
    input  logic                            inStream_TLAST,
    output logic [7:0]                      outByte_TDATA,
    output logic                            outByte_TVALID,
    input  logic                            outByte_TREADY,
    output logic                            outByte_TLAST,
    output logic [31:0]                     pkt_len,
    output logic                            pkt_done,
    output logic                            err_keep,
    output logic                            err_empty_last
);

    localparam int unsigned KW = AXIS_TDATA_WIDTH / 8;
    localparam int unsigned NW = $clog2(KW + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [AXIS_TDATA_WIDTH-1:0]   word_q, word_d;
    logic [NW-1:0]                 n_q, n_d;
    logic [NW-1:0]                 idx_q, idx_d;
    logic                          held_last_q, held_last_d;
    logic                          out_valid_q, out_valid_d;
    logic [7:0]                    out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic [31:0]                   cnt_q, cnt_d;
    logic [31:0]                   len_q, len_d;
    logic                          done_q, done_d;
    logic                          ek_q, ek_d;
    logic                          ee_q, ee_d;

    logic [NW-1:0]                 in_n;
    logic                          in_hole;
    logic                          in_ready_c;
    logic                          in_hs;
    logic                          out_hs;
    logic                          at_last_byte;
    logic [31:0]                   cnt_inc;

    // Select byte 'sel' of a word.
    function automatic logic [7:0] pick_byte(input logic [AXIS_TDATA_WIDTH-1:0] w,
                                             input logic [NW-1:0]               sel);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < int'(KW); i++) begin
            if (sel == NW'(i)) begin
                b = w[8*i +: 8];
            end
        end
        return b;
    endfunction

    // TKEEP decode: byte count from the top set bit, and any hole below it.
    always_comb begin
        in_n    = '0;
        in_hole = 1'b0;
        for (int i = int'(KW) - 1; i >= 0; i--) begin
            if (inStream_TKEEP[i]) begin
                if (in_n == '0) begin
                    in_n = NW'(i + 1);
                end
            end else if (in_n != '0) begin
                in_hole = 1'b1;
            end
        end
    end

    // Next-state, datapath and status logic.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        n_d          = n_q;
        idx_d        = idx_q;
        held_last_d  = held_last_q;
        len_d        = len_q;
        done_d       = 1'b0;
        ek_d         = ek_q;
        ee_d         = ee_q;
        in_ready_c   = 1'b0;

        at_last_byte = (idx_q == n_q - NW'(1));

        // Ready in the final-byte cycle lets the next word load with no bubble.
        case (state_q)
            ST_IDLE:   in_ready_c = ~ap_rst;
            ST_UNPACK: in_ready_c = ~ap_rst & outByte_TREADY & at_last_byte;
            default:   in_ready_c = 1'b0;
        endcase

        in_hs  = inStream_TVALID & in_ready_c;
        out_hs = out_valid_q & outByte_TREADY;

        if (out_hs) begin
            if (at_last_byte) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + NW'(1);
            end
        end

        if (in_hs) begin
            if (in_hole) begin
                ek_d = 1'b1;
            end
            if (in_n != '0) begin
                word_d      = inStream_TDATA;
                n_d         = in_n;
                held_last_d = inStream_TLAST;
                idx_d       = '0;
                state_d     = ST_UNPACK;
            end else if (inStream_TLAST) begin
                ee_d = 1'b1;
            end
        end

        // Byte counter includes the byte handshaken this cycle.
        cnt_inc = cnt_q + (out_hs ? 32'd1 : 32'd0);
        cnt_d   = cnt_inc;
        if (out_hs && out_last_q) begin
            len_d  = cnt_inc;
            done_d = 1'b1;
            cnt_d  = 32'd0;
        end else if (in_hs && (in_n == '0) && inStream_TLAST && (cnt_inc != 32'd0)) begin
            // Empty TLAST word closes a packet whose bytes carried no TLAST.
            len_d  = cnt_inc;
            done_d = 1'b1;
            cnt_d  = 32'd0;
        end

        out_valid_d = (state_d == ST_UNPACK);
        out_data_d  = pick_byte(word_d, idx_d);
        out_last_d  = out_valid_d & held_last_d & (idx_d == n_d - NW'(1));
    end

    // State and output registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            held_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            cnt_q       <= 32'd0;
            len_q       <= 32'd0;
            done_q      <= 1'b0;
            ek_q        <= 1'b0;
            ee_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            held_last_q <= held_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            done_q      <= done_d;
            ek_q        <= ek_d;
            ee_q        <= ee_d;
        end
    end

    assign inStream_TREADY = in_ready_c;
    assign outByte_TVALID  = out_valid_q;
    assign outByte_TDATA   = out_data_q;
    assign outByte_TLAST   = out_last_q;
    assign pkt_len         = len_q;
    assign pkt_done        = done_q;
    assign err_keep        = ek_q;
    assign err_empty_last  = ee_q;

endmodule

// File: tb/tb_axis_byte_unpacker.sv
// Testbench for axis_byte_unpacker: table-driven single-word vectors,
// directed multi-cycle sequences and a randomized run against a
// word-level reference model of the byte stream and packet lengths.
`timescale 1ns/1ps
module tb_axis_byte_unpacker;

    localparam int unsigned W  = 64;
    localparam int unsigned KW = W / 8;

    typedef struct {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } obyte_t;

    typedef struct {
        logic [KW-1:0] keep;
        logic          last;
        int            exp_bytes;
        logic          exp_ek;
        logic          exp_ee;
        int            exp_pulses;
        logic [31:0]   exp_len;
    } vec_t;

    logic          ap_clk;
    logic          ap_rst;
    logic [W-1:0]  inStream_TDATA;
    logic [KW-1:0] inStream_TKEEP;
    logic          inStream_TVALID;
    logic          inStream_TREADY;
    logic          inStream_TLAST;
    logic [7:0]    outByte_TDATA;
    logic          outByte_TVALID;
    logic          outByte_TREADY;
    logic          outByte_TLAST;
    logic [31:0]   pkt_len;
    logic          pkt_done;
    logic          err_keep;
    logic          err_empty_last;

    axis_byte_unpacker #(.AXIS_TDATA_WIDTH(W)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .inStream_TDATA  (inStream_TDATA),
        .inStream_TKEEP  (inStream_TKEEP),
        .inStream_TVALID (inStream_TVALID),
        .inStream_TREADY (inStream_TREADY),
        .inStream_TLAST  (inStream_TLAST),
        .outByte_TDATA   (outByte_TDATA),
        .outByte_TVALID  (outByte_TVALID),
        .outByte_TREADY  (outByte_TREADY),
        .outByte_TLAST   (outByte_TLAST),
        .pkt_len         (pkt_len),
        .pkt_done        (pkt_done),
        .err_keep        (err_keep),
        .err_empty_last  (err_empty_last)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    word_t       drv_q[$];
    obyte_t      exp_q[$];
    logic [31:0] exp_len_q[$];
    logic [31:0] m_tot;
    logic        m_ek;
    logic        m_ee;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   nbytes = 0;
    int   npulse = 0;
    int   nlast_out = 0;
    int   rdy_pct = 100;
    int   in_cyc = 0;
    int   first_valid_cyc = -1;
    int   last_out_cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word contributes bytes 0..n-1; a TLAST word closes
    // the packet and reports its total byte count when that count is non-zero.
    function automatic void model_accept(input word_t w);
        int     n = 0;
        obyte_t b;
        for (int i = 0; i < int'(KW); i++) begin
            if (w.keep[i]) n = i + 1;
        end
        if (w.keep != KW'((1 << n) - 1)) m_ek = 1'b1;
        for (int i = 0; i < n; i++) begin
            b.data = w.data[8*i +: 8];
            b.last = w.last && (i == n - 1);
            exp_q.push_back(b);
        end
        m_tot = m_tot + 32'(n);
        if (w.last) begin
            if (n == 0) m_ee = 1'b1;
            if (m_tot != 32'd0) exp_len_q.push_back(m_tot);
            m_tot = 32'd0;
        end
    endfunction

    // One clock: drive at the falling edge, sample 3 ns later, before the rising edge.
    task automatic step();
        obyte_t e;
        word_t  w;
        @(negedge ap_clk);
        if (drv_q.size() != 0) begin
            inStream_TVALID = 1'b1;
            inStream_TDATA  = drv_q[0].data;
            inStream_TKEEP  = drv_q[0].keep;
            inStream_TLAST  = drv_q[0].last;
        end else begin
            inStream_TVALID = 1'b0;
            inStream_TDATA  = W'({$urandom, $urandom});
            inStream_TKEEP  = KW'($urandom);
            inStream_TLAST  = 1'b0;
        end
        outByte_TREADY = (int'($urandom_range(99, 0)) < rdy_pct);
        #3;
        cyc++;
        if (inStream_TVALID && inStream_TREADY) begin
            w = drv_q.pop_front();
            model_accept(w);
            in_cyc = cyc;
        end
        if (outByte_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall) begin
            chk("hold_valid", 32'(outByte_TVALID), 32'd1);
            chk("hold_data", 32'(outByte_TDATA), 32'(prev_data));
            chk("hold_last", 32'(outByte_TLAST), 32'(prev_last));
        end
        if (outByte_TVALID && outByte_TREADY) begin
            nbytes++;
            last_out_cyc = cyc;
            if (outByte_TLAST) nlast_out++;
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL extra_byte: got 0x%02h, required no byte", outByte_TDATA);
            end else begin
                e = exp_q.pop_front();
                chk("byte_data", 32'(outByte_TDATA), 32'(e.data));
                chk("byte_last", 32'(outByte_TLAST), 32'(e.last));
            end
        end
        prev_stall = outByte_TVALID && !outByte_TREADY;
        prev_data  = outByte_TDATA;
        prev_last  = outByte_TLAST;
        if (pkt_done) begin
            npulse++;
            if (exp_len_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL extra_pulse: got pkt_len 0x%0h, required no pulse", pkt_len);
            end else begin
                chk("pkt_len_pulse", pkt_len, exp_len_q.pop_front());
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        while ((drv_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        chk("drain_words", 32'(drv_q.size()), 32'd0);
        chk("drain_bytes", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
        chk("drain_pulses", 32'(exp_len_q.size()), 32'd0);
    endtask

    // Asserts reset immediately, holds it for two cycles, and drops model state.
    task automatic do_reset();
        ap_rst          = 1'b1;
        inStream_TVALID = 1'b0;
        #1;
        chk("rst_tvalid", 32'(outByte_TVALID), 32'd0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        drv_q.delete();
        exp_q.delete();
        exp_len_q.delete();
        m_tot      = 32'd0;
        m_ek       = 1'b0;
        m_ee       = 1'b0;
        prev_stall = 1'b0;
    endtask

    function automatic word_t mk(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        return w;
    endfunction

    initial begin
        vec_t vt[8];
        int   b0;
        int   p0;
        int   l0;
        int   c;

        vt[0] = '{8'hFF, 1'b1, 8, 1'b0, 1'b0, 1, 32'd8};
        vt[1] = '{8'h01, 1'b1, 1, 1'b0, 1'b0, 1, 32'd1};
        vt[2] = '{8'h05, 1'b1, 3, 1'b1, 1'b0, 1, 32'd3};
        vt[3] = '{8'h80, 1'b1, 8, 1'b1, 1'b0, 1, 32'd8};
        vt[4] = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 0, 32'd0};
        vt[5] = '{8'h00, 1'b0, 0, 1'b0, 1'b0, 0, 32'd0};
        vt[6] = '{8'h0F, 1'b0, 4, 1'b0, 1'b0, 0, 32'd0};
        vt[7] = '{8'h7F, 1'b1, 7, 1'b0, 1'b0, 1, 32'd7};

        ap_rst          = 1'b1;
        inStream_TVALID = 1'b0;
        inStream_TDATA  = '0;
        inStream_TKEEP  = '0;
        inStream_TLAST  = 1'b0;
        outByte_TREADY  = 1'b1;
        m_tot = 32'd0;
        m_ek  = 1'b0;
        m_ee  = 1'b0;

        // Reset values
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rst_out_valid", 32'(outByte_TVALID), 32'd0);
        chk("rst_out_last", 32'(outByte_TLAST), 32'd0);
        chk("rst_out_data", 32'(outByte_TDATA), 32'd0);
        chk("rst_in_ready", 32'(inStream_TREADY), 32'd0);
        chk("rst_pkt_len", pkt_len, 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_err_keep", 32'(err_keep), 32'd0);
        chk("rst_err_empty", 32'(err_empty_last), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Single-word vector table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            rdy_pct = 100;
            b0 = nbytes;
            p0 = npulse;
            drv_q.push_back(mk(W'({$urandom, $urandom}), vt[v].keep, vt[v].last));
            run_until_idle(50);
            chk($sformatf("vec%0d_bytes", v), 32'(nbytes - b0), 32'(vt[v].exp_bytes));
            chk($sformatf("vec%0d_err_keep", v), 32'(err_keep), 32'(vt[v].exp_ek));
            chk($sformatf("vec%0d_err_empty", v), 32'(err_empty_last), 32'(vt[v].exp_ee));
            chk($sformatf("vec%0d_pulses", v), 32'(npulse - p0), 32'(vt[v].exp_pulses));
            chk($sformatf("vec%0d_pkt_len", v), pkt_len, vt[v].exp_len);
        end

        // One full word: latency, back-to-back bytes, length
        do_reset();
        rdy_pct = 100;
        b0 = nbytes;
        p0 = npulse;
        first_valid_cyc = -1;
        drv_q.push_back(mk(64'h0807060504030201, 8'hFF, 1'b1));
        run_until_idle(40);
        chk("w1_latency", 32'(first_valid_cyc - in_cyc), 32'd1);
        chk("w1_bytes", 32'(nbytes - b0), 32'd8);
        chk("w1_span", 32'(last_out_cyc - first_valid_cyc), 32'd7);
        chk("w1_pkt_len", pkt_len, 32'd8);
        chk("w1_pulses", 32'(npulse - p0), 32'd1);

        // Two words, no bubble between them
        do_reset();
        rdy_pct = 100;
        b0 = nbytes;
        first_valid_cyc = -1;
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'hFF, 1'b0));
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h07, 1'b1));
        run_until_idle(40);
        chk("w2_bytes", 32'(nbytes - b0), 32'd11);
        chk("w2_span", 32'(last_out_cyc - first_valid_cyc), 32'd10);
        chk("w2_pkt_len", pkt_len, 32'd11);

        // Three words under 50% backpressure
        do_reset();
        rdy_pct = 50;
        b0 = nbytes;
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'hFF, 1'b0));
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'hFF, 1'b0));
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h07, 1'b1));
        run_until_idle(400);
        chk("w3_bytes", 32'(nbytes - b0), 32'd19);
        chk("w3_pkt_len", pkt_len, 32'd19);

        // Holey TKEEP then empty TLAST word
        do_reset();
        rdy_pct = 100;
        b0 = nbytes;
        p0 = npulse;
        l0 = nlast_out;
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h05, 1'b0));
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h00, 1'b1));
        run_until_idle(40);
        chk("hole_bytes", 32'(nbytes - b0), 32'd3);
        chk("hole_err_keep", 32'(err_keep), 32'd1);
        chk("hole_err_empty", 32'(err_empty_last), 32'd1);
        chk("hole_pkt_len", pkt_len, 32'd3);
        chk("hole_pulses", 32'(npulse - p0), 32'd1);
        chk("hole_no_tlast", 32'(nlast_out - l0), 32'd0);

        // Reset in the middle of a packet
        do_reset();
        rdy_pct = 100;
        b0 = nbytes;
        c = 0;
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'hFF, 1'b1));
        while (nbytes - b0 < 3 && c < 20) begin
            step();
            c++;
        end
        chk("midrst_reached", 32'(nbytes - b0), 32'd3);
        @(posedge ap_clk);
        #1;
        do_reset();
        @(posedge ap_clk);
        #1;
        chk("midrst_in_ready", 32'(inStream_TREADY), 32'd1);
        b0 = nbytes;
        repeat (10) step();
        chk("midrst_no_bytes", 32'(nbytes - b0), 32'd0);
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h03, 1'b1));
        run_until_idle(40);
        chk("midrst_pkt_len", pkt_len, 32'd2);

        // Counter wrap: preload the counter, then a 2-byte packet
        do_reset();
        rdy_pct = 100;
        step();
        force dut.cnt_q = 32'hFFFF_FFFF;
        step();
        step();
        release dut.cnt_q;
        m_tot = 32'hFFFF_FFFF;
        drv_q.push_back(mk(W'({$urandom, $urandom}), 8'h03, 1'b1));
        run_until_idle(40);
        chk("wrap_pkt_len", pkt_len, 32'd1);

        // Randomized words against the reference model
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            rdy_pct = (ph == 0) ? 70 : 30;
            for (int i = 0; i < 80; i++) begin
                logic [KW-1:0] k;
                case ($urandom_range(3, 0))
                    0:       k = KW'($urandom);
                    1:       k = '1;
                    2:       k = KW'((1 << $urandom_range(KW, 0)) - 1);
                    default: k = '0;
                endcase
                drv_q.push_back(mk(W'({$urandom, $urandom}), k, ($urandom_range(3, 0) == 0)));
            end
            run_until_idle(4000);
            chk($sformatf("rand%0d_err_keep", ph), 32'(err_keep), 32'(m_ek));
            chk($sformatf("rand%0d_err_empty", ph), 32'(err_empty_last), 32'(m_ee));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
